// File: rtl/frame_control_if.sv
// frame_control_if: stream, pipe and status signals of the frame controller
interface frame_control_if #(parameter int DATA_W = 64, parameter int CNT_W = 32);
  logic start;
  logic [CNT_W-1:0] in_beats, out_beats;
  logic in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic pipe_in_valid, pipe_in_ready;
  logic [DATA_W-1:0] pipe_in_data;
  logic pipe_reset;
  logic pipe_out_valid, pipe_out_ready;
  logic [DATA_W-1:0] pipe_out_data;
  logic out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic busy, done, overflow;
  modport slave(
    input start, in_beats, out_beats, in_valid, in_data, pipe_in_ready,
          pipe_out_valid, pipe_out_data, out_ready,
    output in_ready, pipe_in_valid, pipe_in_data, pipe_reset, pipe_out_ready,
           out_valid, out_data, busy, done, overflow
  );
  modport master(
    output start, in_beats, out_beats, in_valid, in_data, pipe_in_ready,
           pipe_out_valid, pipe_out_data, out_ready,
    input in_ready, pipe_in_valid, pipe_in_data, pipe_reset, pipe_out_ready,
          out_valid, out_data, busy, done, overflow
  );
endinterface

// File: rtl/frame_control.sv
// frame_control: resets the pipe, admits in_beats inputs and forwards out_beats outputs per frame
module frame_control #(
  parameter int DATA_W = 64,
  parameter int CNT_W = 32,
  parameter int RST_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  frame_control_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, PRST = 2'd1, RUN = 2'd2, DONE = 2'd3;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] in_len_q, in_len_d, out_len_q, out_len_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, rc_q, rc_d;
  logic ovf_q, ovf_d;
  logic run, in_open, out_open, in_fire, out_fire, drop;
  always_comb begin
    run = state_q == RUN;
    in_open = run && in_cnt_q != in_len_q;
    out_open = run && out_cnt_q != out_len_q;
    in_fire = in_open && bus.in_valid && bus.pipe_in_ready;
    out_fire = out_open && bus.pipe_out_valid && bus.out_ready;
    drop = bus.pipe_out_valid && (state_q == DONE || (run && !out_open));
    state_d = state_q;
    in_len_d = in_len_q;
    out_len_d = out_len_q;
    in_cnt_d = in_fire ? in_cnt_q + CNT_W'(1) : in_cnt_q;
    out_cnt_d = out_fire ? out_cnt_q + CNT_W'(1) : out_cnt_q;
    rc_d = rc_q;
    ovf_d = ovf_q || drop;
    if ((state_q == IDLE || state_q == DONE) && bus.start) begin
      state_d = PRST;
      in_len_d = bus.in_beats;
      out_len_d = bus.out_beats;
      in_cnt_d = '0;
      out_cnt_d = '0;
      rc_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == PRST) begin
      state_d = rc_q == RST_LAST ? RUN : PRST;
      rc_d = rc_q + CNT_W'(1);
    end else if (run && in_cnt_d == in_len_q && out_cnt_d == out_len_q) begin
      state_d = DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in_len_q <= '0;
      out_len_q <= '0;
      in_cnt_q <= '0;
      out_cnt_q <= '0;
      rc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_len_q <= in_len_d;
      out_len_q <= out_len_d;
      in_cnt_q <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      rc_q <= rc_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.pipe_in_valid = in_open && bus.in_valid;
  assign bus.in_ready = in_open && bus.pipe_in_ready;
  assign bus.pipe_in_data = bus.in_data;
  assign bus.out_valid = out_open && bus.pipe_out_valid;
  assign bus.pipe_out_ready = out_open ? bus.out_ready : (run || state_q == DONE);
  assign bus.out_data = bus.pipe_out_data[DATA_W-1:0];
  assign bus.pipe_reset = state_q == IDLE || state_q == PRST;
  assign bus.busy = state_q == PRST || run;
  assign bus.done = state_q == DONE;
  assign bus.overflow = ovf_q;
endmodule
